md_alu_control: RTL and testbench

Parametrised ALU control with an integrated multi-cycle multiply/divide sequencer. It decodes `UC_input`/`funct` into the 3-bit ALU operation code for single-cycle ops, exactly as the existing ALU control does. It also executes MIPS mult/multu/div/divu iteratively into HI/LO registers and serves mfhi/mflo/mthi/mtlo. It sits between the main control unit and the ALU/writeback mux, and stalls the pipeline while a HI/LO operation is in flight.

---
 rtl/md_alu_pkg.sv | 46 ++++
 rtl/md_iter_core.sv | 136 +++++++++++++
 rtl/md_alu_control.sv | 105 ++++++++++
 tb/tb_md_alu_control.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_alu_pkg.sv
// Shared constants for the ALU control and multiply/divide sequencer.
package md_alu_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOP = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [2:0] UC_RTYPE = 3'b000;
    localparam logic [2:0] UC_OR    = 3'b001;
    localparam logic [2:0] UC_ADD   = 3'b010;
    localparam logic [2:0] UC_AND   = 3'b011;
    localparam logic [2:0] UC_SUB   = 3'b110;
    localparam logic [2:0] UC_SLT   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Iterative shift-add multiplier / restoring divider over operand magnitudes,
// with a final sign fix-up cycle.
module md_iter_core
    import md_alu_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output md_state_t        state,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               div_r;
    logic               neg_q;
    logic               neg_r;
    logic               sa;
    logic               sb;
    logic               div_zero;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_neg;

    assign sa       = is_signed & a[WIDTH-1];
    assign sb       = is_signed & b[WIDTH-1];
    assign abs_a    = sa ? -a : a;
    assign abs_b    = sb ? -b : b;
    assign div_zero = is_div & (b == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = div_zero ? FIX : RUN;
            RUN:     if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply: hi_r accumulates, lo_r shifts out multiplier bits.
    // Divide: {hi_r, lo_r} shifts left, lo_r collects quotient bits.
    assign add_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag} : '0);
    assign rem_sh  = {hi_r, lo_r[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, mag};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            mag   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    div_r <= is_div;
                    cnt   <= CW'(WIDTH - 1);
                    hi_r  <= '0;
                    if (div_zero) begin
                        mag   <= '0;
                        hi_r  <= a;
                        lo_r  <= '1;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (is_div) begin
                        mag   <= abs_b;
                        lo_r  <= abs_a;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                    end else begin
                        mag   <= abs_a;
                        lo_r  <= abs_b;
                        neg_q <= sa ^ sb;
                        neg_r <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (div_r) begin
                        if (!trial[WIDTH]) begin
                            hi_r <= trial[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_r <= rem_sh[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_r <= add_sum[WIDTH:1];
                        lo_r <= {add_sum[0], lo_r[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod_neg = -{hi_r, lo_r};
    assign done     = (state == FIX);

    always_comb begin
        res_hi = hi_r;
        res_lo = lo_r;
        if (div_r) begin
            if (neg_r) res_hi = -hi_r;
            if (neg_q) res_lo = -lo_r;
        end else if (neg_q) begin
            res_hi = prod_neg[2*WIDTH-1:WIDTH];
            res_lo = prod_neg[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/md_alu_control.sv
// ALU control decode plus HI/LO register file and multi-cycle mul/div
// acceptance and stall logic.
module md_alu_control
    import md_alu_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [2:0]       UC_input,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [2:0]       AC_output,
    output logic             illegal,
    output logic             md_stall,
    output logic             md_busy,
    output logic             md_sel,
    output logic [WIDTH-1:0] md_result
);

    md_state_t        state;
    logic             done;
    logic             is_md;
    logic             accept;
    logic             start;
    logic             is_div;
    logic             is_signed;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    always_comb begin
        AC_output = OP_NOP;
        illegal   = 1'b0;
        is_md     = 1'b0;
        case (UC_input)
            UC_RTYPE: begin
                case (funct)
                    F_ADD: AC_output = OP_ADD;
                    F_SUB: AC_output = OP_SUB;
                    F_SLT: AC_output = OP_SLT;
                    F_AND: AC_output = OP_AND;
                    F_OR:  AC_output = OP_OR;
                    F_XOR: AC_output = OP_XOR;
                    F_NOR: AC_output = OP_NOR;
                    F_SLL: AC_output = OP_NOP;
                    F_MULT, F_MULTU, F_DIV, F_DIVU,
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO: is_md = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            UC_ADD:  AC_output = OP_ADD;
            UC_SUB:  AC_output = OP_SUB;
            UC_SLT:  AC_output = OP_SLT;
            UC_AND:  AC_output = OP_AND;
            UC_OR:   AC_output = OP_OR;
            default: ;
        endcase
    end

    assign md_busy   = (state != IDLE);
    assign md_stall  = valid_in & is_md & md_busy;
    assign accept    = valid_in & is_md & ~md_busy;
    assign is_div    = (funct == F_DIV) | (funct == F_DIVU);
    assign is_signed = (funct == F_MULT) | (funct == F_DIV);
    assign start     = accept & (is_div | is_signed | funct == F_MULTU);
    assign md_sel    = accept & ((funct == F_MFHI) | (funct == F_MFLO));

    always_comb begin
        md_result = '0;
        if (md_sel) md_result = (funct == F_MFHI) ? hi : lo;
    end

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (rs_val),
        .b         (rt_val),
        .state     (state),
        .done      (done),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    // Moves and sequencer results never collide: moves need md_busy=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (accept) begin
            if (funct == F_MTHI) hi <= rs_val;
            if (funct == F_MTLO) lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_md_alu_control.sv
// Randomised and directed bench for md_alu_control against an
// arithmetic reference model of the HI/LO operations.
module tb_md_alu_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [2:0]  UC_input;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [2:0]  AC_output;
    logic        illegal;
    logic        md_stall;
    logic        md_busy;
    logic        md_sel;
    logic [31:0] md_result;

    int checks   = 0;
    int failures = 0;

    md_alu_control #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .UC_input  (UC_input),
        .funct     (funct),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .AC_output (AC_output),
        .illegal   (illegal),
        .md_stall  (md_stall),
        .md_busy   (md_busy),
        .md_sel    (md_sel),
        .md_result (md_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] uc,
                         input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        valid_in = v;
        UC_input = uc;
        funct    = f;
        rs_val   = a;
        rt_val   = b;
    endtask

    // Reference results from plain integer arithmetic.
    function automatic void model(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] hi,
                                  output logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = int'(a);
        sb = int'(b);
        hi = '0;
        lo = '0;
        if (f == 6'b011000) begin
            sp = longint'(sa) * longint'(sb);
            {hi, lo} = sp;
        end else if (f == 6'b011001) begin
            up = {32'd0, a} * {32'd0, b};
            {hi, lo} = up;
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (f == 6'b011010) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                lo = sa / sb;
                hi = sa % sb;
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic run_md(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
        int          exp_busy;
        model(f, a, b, eh, el);
        exp_busy = ((f == 6'b011010 || f == 6'b011011) && b == 0) ? 1 : 33;
        drive(1'b1, 3'b000, f, a, b);
        #1;
        check({tag, ":accept"}, {63'd0, md_stall}, 64'd0);
        tick();
        drive(1'b0, 3'b000, 6'b100000, '0, '0);
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            tick();
        end
        check({tag, ":busy"}, 64'(n), 64'(exp_busy));
        drive(1'b1, 3'b000, 6'b010000, '0, '0);
        #1;
        check({tag, ":hi"}, {31'd0, md_sel, md_result}, {31'd0, 1'b1, eh});
        tick();
        drive(1'b1, 3'b000, 6'b010010, '0, '0);
        #1;
        check({tag, ":lo"}, {31'd0, md_sel, md_result}, {31'd0, 1'b1, el});
        tick();
        drive(1'b0, 3'b000, 6'b100000, '0, '0);
    endtask

    logic [5:0] dec_f [18] = '{
        6'b100000, 6'b100010, 6'b101010, 6'b100100, 6'b100101, 6'b100110,
        6'b100111, 6'b000000, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
        6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b111111, 6'b000001};
    logic [3:0] dec_e [18] = '{
        4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b0101,
        4'b0100, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
        4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1011, 4'b1011};
    logic [2:0] uc_e [8] = '{
        3'b011, 3'b001, 3'b010, 3'b000, 3'b011, 3'b011, 3'b110, 3'b111};

    initial begin
        logic [5:0] ops [4];
        logic [5:0] f;
        logic [31:0] a;
        logic [31:0] b;
        int n;
        ops = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

        reset = 1'b1;
        drive(1'b0, 3'b000, 6'b100000, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", {63'd0, md_busy}, 64'd0);
        drive(1'b1, 3'b000, 6'b010000, '0, '0);
        #1;
        check("rst_hi", {31'd0, md_sel, md_result}, {31'd0, 1'b1, 32'd0});
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 3'b000, dec_f[i], '0, '0);
            #1;
            check($sformatf("dec_f%b", dec_f[i]), {60'd0, illegal, AC_output},
                  {60'd0, dec_e[i]});
        end
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 3'(i), 6'b111111, '0, '0);
            #1;
            check($sformatf("dec_uc%0d", i), {60'd0, illegal, AC_output},
                  {61'd0, uc_e[i]});
        end
        tick();

        run_md("mult", 6'b011000, 32'hFFFF_FFFD, 32'd5);
        run_md("multu", 6'b011001, 32'hFFFF_FFFD, 32'd5);
        run_md("div", 6'b011010, 32'd7, 32'hFFFF_FFFE);
        run_md("divu", 6'b011011, 32'd100, 32'd7);
        run_md("divmin", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("divz", 6'b011011, 32'd1234, 32'd0);
        run_md("sdivz", 6'b011010, 32'hFFFF_0000, 32'd0);

        for (int i = 0; i < 40; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 9);
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_md($sformatf("rnd%0d", i), f, a, b);
        end

        // mflo held during a multiply, with an add slipping through
        drive(1'b1, 3'b000, 6'b011000, 32'd7, 32'd9);
        tick();
        drive(1'b1, 3'b000, 6'b100000, 32'd1, 32'd1);
        #1;
        check("add_ac", {63'd0, md_stall, AC_output}, {60'd0, 4'b0010});
        tick();
        drive(1'b1, 3'b000, 6'b010010, '0, '0);
        n = 0;
        #1;
        while (md_stall && n < 100) begin
            n++;
            tick();
        end
        check("mflo_stall", 64'(n), 64'd32);
        check("mflo_val", {31'd0, md_sel, md_result}, {31'd0, 1'b1, 32'd63});
        tick();

        // reset aborts a multiply in flight
        drive(1'b1, 3'b000, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(1'b0, 3'b000, 6'b100000, '0, '0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 3'b000, 6'b010000, '0, '0);
        #1;
        check("rst_mid", {31'd0, md_busy, md_result}, 64'd0);
        tick();
        repeat (40) tick();
        check("rst_stay", {63'd0, md_busy}, 64'd0);
        drive(1'b1, 3'b000, 6'b010010, '0, '0);
        #1;
        check("rst_lo", {31'd0, md_sel, md_result}, {31'd0, 1'b1, 32'd0});

        drive(1'b1, 3'b000, 6'b010001, 32'hA5A5_A5A5, '0);
        #1;
        check("mthi_busy", {62'd0, md_stall, md_busy}, 64'd0);
        tick();
        drive(1'b1, 3'b000, 6'b010011, 32'h1234_5678, '0);
        #1;
        check("mfhi_a5", {32'd0, dut.hi}, 64'hA5A5_A5A5);
        tick();
        drive(1'b1, 3'b000, 6'b010000, '0, '0);
        #1;
        check("mthi_rd", {31'd0, md_sel, md_result}, {31'd0, 1'b1, 32'hA5A5_A5A5});
        tick();
        drive(1'b1, 3'b000, 6'b010010, '0, '0);
        #1;
        check("mtlo_rd", {31'd0, md_sel, md_result}, {31'd0, 1'b1, 32'h1234_5678});
        tick();
        drive(1'b0, 3'b000, 6'b100000, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
